imem_loader: RTL and testbench

- Boot-time writer for the byte-addressed, big-endian instruction memory (128 bytes, 32 words). The fetch path only reads that memory.
- Accepts a stream of program bytes over a valid/ready byte handshake and assembles each group of 4 bytes into a 32-bit word. Issues one-cycle word writes to the memory write port.
- Holds the CPU in reset/stall until the program has been loaded.
- Loading ends on the first HALT instruction (opcode 6'b111111) or when memory is full.

---
 rtl/imem_loader.sv | 160 ++++++++++++++++
 tb/tb_imem_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Boot-time writer for the byte-addressed, big-endian instruction memory.
// Program bytes arrive over a valid/ready handshake. Each group of four
// bytes is packed MSB-first into a 32-bit word. Each word goes to the memory
// write port as a one-cycle strobe. The CPU is held off fetch until loading
// ends, either on the first HALT word (opcode 6'b111111) or when the last
// word of memory has been written.
//
// Parameters
//   DEPTH_BYTES : instruction memory size in bytes (multiple of 4)
//   ADDR_W      : width of the write address
//
// Ports
//   CLK        in   rising-edge clock
//   Reset      in   asynchronous active-low reset
//   Start      in   one-cycle pulse that begins a load (IDLE or DONE only)
//   ByteIn     in   program byte; byte 0 of a word is the MSB
//   ByteValid  in   ByteIn is valid
//   ByteReady  out  loader accepts ByteIn this cycle (LOAD state)
//   WrEn       out  one-cycle word write strobe
//   WAddr      out  byte address of the word being written (multiple of 4)
//   WData      out  word being written, [31:24] -> WAddr+0
//   CpuHold    out  high while the CPU must not fetch
//   Done       out  high once a load has completed
//   WordCount  out  words written in the current or last load
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int DEPTH_BYTES = 128,
    parameter int ADDR_W      = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Start,
    input  logic [7:0]        ByteIn,
    input  logic              ByteValid,
    output logic              ByteReady,
    output logic              WrEn,
    output logic [ADDR_W-1:0] WAddr,
    output logic [31:0]       WData,
    output logic              CpuHold,
    output logic              Done,
    output logic [5:0]        WordCount
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_BYTES - 4);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);
    localparam logic [5:0]        HALT_OP   = 6'b111111;

    state_t              state_q,    state_d;
    logic                wr_en_q,    wr_en_d;
    logic [ADDR_W-1:0]   waddr_q,    waddr_d;
    logic [31:0]         wdata_q,    wdata_d;
    logic                done_q,     done_d;
    logic [5:0]          word_cnt_q, word_cnt_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [31:0]         shift_q,    shift_d;

    // Word as it looks once the byte on ByteIn is shifted in.
    logic [31:0]         assembled;
    logic                last_word;

    assign assembled = {shift_q[23:0], ByteIn};

    // A load ends on a HALT opcode or after the top word of memory.
    assign last_word = (wdata_q[31:26] == HALT_OP) || (waddr_q == LAST_ADDR);

    always_comb begin
        state_d    = state_q;
        wr_en_d    = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        done_d     = done_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // A byte offered alongside Start is not taken: ByteReady
                // is still low in this cycle.
                if (Start) begin
                    state_d    = S_LOAD;
                    waddr_d    = '0;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    done_d     = 1'b0;
                end
            end

            S_LOAD: begin
                // Start is deliberately ignored here.
                if (ByteValid) begin
                    shift_d    = assembled;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                        wr_en_d = 1'b1;
                        wdata_d = assembled;
                    end
                end
            end

            S_WRITE: begin
                word_cnt_d = word_cnt_q + 6'd1;
                if (last_word) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_LOAD;
                    waddr_d = waddr_q + WORD_STEP;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            wr_en_q    <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_en_q    <= wr_en_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
        end
    end

    // Handshake and hold are decoded straight from state so that CpuHold
    // rises in the very cycle the state re-enters LOAD from DONE.
    assign ByteReady = (state_q == S_LOAD);
    assign CpuHold   = (state_q != S_DONE);

    assign WrEn      = wr_en_q;
    assign WAddr     = waddr_q;
    assign WData     = wdata_q;
    assign Done      = done_q;
    assign WordCount = word_cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Directed bench for imem_loader. A cycle table covers the basic two-word
// load. Hand-written sequences cover stalled bytes, a full memory, reset
// mid-load, Start during LOAD and a restart from DONE.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Start;
    logic [7:0]  ByteIn;
    logic        ByteValid;
    logic        ByteReady;
    logic        WrEn;
    logic [31:0] WAddr;
    logic [31:0] WData;
    logic        CpuHold;
    logic        Done;
    logic [5:0]  WordCount;

    imem_loader #(.DEPTH_BYTES(128), .ADDR_W(32)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .Start     (Start),
        .ByteIn    (ByteIn),
        .ByteValid (ByteValid),
        .ByteReady (ByteReady),
        .WrEn      (WrEn),
        .WAddr     (WAddr),
        .WData     (WData),
        .CpuHold   (CpuHold),
        .Done      (Done),
        .WordCount (WordCount)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Write log and handshake monitor.
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic        mon_en = 1'b0;
    int          hs_bad = 0;

    always @(negedge CLK) begin
        if (WrEn) begin
            wa_q.push_back(WAddr);
            wd_q.push_back(WData);
        end
        if (mon_en && !Done && (ByteReady == WrEn)) hs_bad++;
    end

    typedef struct {
        logic        start;
        logic        valid;
        logic [7:0]  b;
        logic        ready;
        logic        wren;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic        hold;
        logic        done;
        logic [5:0]  wc;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic v, input logic [7:0] b,
                                input logic rdy, input logic we, input logic [31:0] wa,
                                input logic [31:0] wd, input logic h, input logic d,
                                input logic [5:0] wc);
        vec_t r;
        r.start = st; r.valid = v; r.b = b;
        r.ready = rdy; r.wren = we; r.waddr = wa; r.wdata = wd;
        r.hold = h; r.done = d; r.wc = wc;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge CLK);
        Reset = 1'b0; Start = 1'b0; ByteValid = 1'b0; ByteIn = 8'h00;
        repeat (2) @(negedge CLK);
        Reset = 1'b1;
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic start_pulse();
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
    endtask

    // Called at a negedge; presents one byte until it is taken.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        ByteIn = b; ByteValid = 1'b1;
        while (!ByteReady && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) check("byte accept timeout", 64'(n), 64'(0));
        @(negedge CLK);
        ByteValid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!Done && n < 400) begin
            @(negedge CLK);
            n++;
        end
        check(name, 64'(Done), 64'(1));
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
    endtask

    vec_t vecs[14];

    initial begin
        Reset = 1'b0; Start = 1'b0; ByteValid = 1'b0; ByteIn = 8'h00;

        // Cycle table: two-word load with ByteValid held high. The first
        // row offers a byte together with Start, which must not be taken.
        vecs[0]  = mk(1, 1, 8'hAA, 0, 0, 0, 32'h00000000, 1, 0, 0);
        vecs[1]  = mk(0, 1, 8'h40, 1, 0, 0, 32'h00000000, 1, 0, 0);
        vecs[2]  = mk(0, 1, 8'h01, 1, 0, 0, 32'h00000000, 1, 0, 0);
        vecs[3]  = mk(0, 1, 8'h00, 1, 0, 0, 32'h00000000, 1, 0, 0);
        vecs[4]  = mk(0, 1, 8'h0A, 1, 0, 0, 32'h00000000, 1, 0, 0);
        vecs[5]  = mk(0, 1, 8'hFC, 0, 1, 0, 32'h4001000A, 1, 0, 0);
        vecs[6]  = mk(0, 1, 8'hFC, 1, 0, 4, 32'h4001000A, 1, 0, 1);
        vecs[7]  = mk(0, 1, 8'h00, 1, 0, 4, 32'h4001000A, 1, 0, 1);
        vecs[8]  = mk(0, 1, 8'h00, 1, 0, 4, 32'h4001000A, 1, 0, 1);
        vecs[9]  = mk(0, 1, 8'h00, 1, 0, 4, 32'h4001000A, 1, 0, 1);
        vecs[10] = mk(0, 0, 8'h00, 0, 1, 4, 32'hFC000000, 1, 0, 1);
        vecs[11] = mk(0, 0, 8'h00, 0, 0, 4, 32'hFC000000, 0, 1, 2);
        vecs[12] = mk(1, 1, 8'h55, 0, 0, 4, 32'hFC000000, 0, 1, 2);
        vecs[13] = mk(0, 0, 8'h00, 1, 0, 0, 32'hFC000000, 1, 0, 0);

        reset_dut();
        #1;
        check("reset ctl", {ByteReady, WrEn, CpuHold, Done, WordCount},
              {1'b0, 1'b0, 1'b1, 1'b0, 6'd0});
        check("reset waddr/wdata", {WAddr, WData}, 64'd0);

        for (int i = 0; i < 14; i++) begin
            @(negedge CLK);
            Start = vecs[i].start; ByteValid = vecs[i].valid; ByteIn = vecs[i].b;
            #1;
            check($sformatf("vec%0d ctl", i),
                  {ByteReady, WrEn, CpuHold, Done, WordCount, WAddr},
                  {vecs[i].ready, vecs[i].wren, vecs[i].hold, vecs[i].done,
                   vecs[i].wc, vecs[i].waddr});
            check($sformatf("vec%0d wdata", i), 64'(WData), 64'(vecs[i].wdata));
        end
        @(negedge CLK);
        Start = 1'b0; ByteValid = 1'b0;

        // Stalled stream: three idle cycles before every byte.
        reset_dut();
        clear_log();
        start_pulse();
        hs_bad = 0;
        mon_en = 1'b1;
        begin
            logic [7:0] s [8];
            s = '{8'h40, 8'h01, 8'h00, 8'h0A, 8'hFC, 8'h00, 8'h00, 8'h00};
            for (int i = 0; i < 8; i++) begin
                repeat (3) @(negedge CLK);
                send_byte(s[i]);
            end
        end
        wait_done("gap done");
        mon_en = 1'b0;
        check("gap writes", 64'(wa_q.size()), 64'(2));
        check("gap w0", {wa_q[0], wd_q[0]}, {32'd0, 32'h4001000A});
        check("gap w1", {wa_q[1], wd_q[1]}, {32'd4, 32'hFC000000});
        check("gap final", {CpuHold, Done, WordCount}, {1'b0, 1'b1, 6'd2});
        check("gap ready vs write", 64'(hs_bad), 64'(0));

        // Full memory: 32 non-HALT words, then an extra byte is offered.
        reset_dut();
        clear_log();
        start_pulse();
        for (int k = 0; k < 32; k++) begin
            send_byte(8'h00);
            send_byte(8'h00);
            send_byte(8'h00);
            send_byte(8'(k));
        end
        wait_done("full done");
        check("full writes", 64'(wa_q.size()), 64'(32));
        check("full last", {wa_q[31], wd_q[31]}, {32'd124, 32'h0000001F});
        check("full count", 64'(WordCount), 64'(32));
        begin
            int rdy_seen;
            rdy_seen = 0;
            ByteIn = 8'h77; ByteValid = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(negedge CLK);
                if (ByteReady) rdy_seen++;
            end
            ByteValid = 1'b0;
            check("byte 129 refused", 64'(rdy_seen), 64'(0));
            check("full writes after", 64'(wa_q.size()), 64'(32));
        end

        // Reset mid-load: WData still holds 0x1F from the full load.
        clear_log();
        start_pulse();
        send_byte(8'h11);
        send_byte(8'h22);
        Reset = 1'b0;
        #1;
        check("midreset ctl", {ByteReady, WrEn, CpuHold, Done, WordCount},
              {1'b0, 1'b0, 1'b1, 1'b0, 6'd0});
        check("midreset waddr/wdata", {WAddr, WData}, 64'd0);
        @(negedge CLK);
        Reset = 1'b1;
        @(negedge CLK);
        check("midreset no write", 64'(wa_q.size()), 64'(0));
        start_pulse();
        begin
            logic [7:0] s [8];
            s = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hFC, 8'h00, 8'h00, 8'h00};
            for (int i = 0; i < 8; i++) send_byte(s[i]);
        end
        wait_done("midreset done");
        check("midreset w0", {wa_q[0], wd_q[0]}, {32'd0, 32'h11223344});
        check("midreset w1 addr", 64'(wa_q[1]), 64'(4));
        check("midreset count", 64'(WordCount), 64'(2));

        // Start pulsed during LOAD after one byte is ignored.
        reset_dut();
        clear_log();
        start_pulse();
        send_byte(8'hFC);
        start_pulse();
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_done("load-start done");
        check("load-start writes", 64'(wa_q.size()), 64'(1));
        check("load-start w0", {wa_q[0], wd_q[0]}, {32'd0, 32'hFC000000});
        check("load-start count", 64'(WordCount), 64'(1));

        // Restart from DONE.
        clear_log();
        start_pulse();
        check("restart hold/done", {CpuHold, Done, ByteReady}, {1'b1, 1'b0, 1'b1});
        send_byte(8'hFC);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_done("restart done");
        check("restart writes", 64'(wa_q.size()), 64'(1));
        check("restart w0", {wa_q[0], wd_q[0]}, {32'd0, 32'hFC000000});
        check("restart final", {CpuHold, Done, WordCount}, {1'b0, 1'b1, 6'd1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
